// File: rtl/pwm_ctrl_pkg.sv
// Shared constants for the PWM configuration scheduler: state encoding and
// default widths / ramp step.
package pwm_ctrl_pkg;

  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] RUN_ENC  = 2'd1;
  localparam logic [1:0] RAMP_ENC = 2'd2;
  localparam logic [1:0] STOP_ENC = 2'd3;

  typedef enum logic [1:0] {
    IDLE = IDLE_ENC,
    RUN  = RUN_ENC,
    RAMP = RAMP_ENC,
    STOP = STOP_ENC
  } sched_state_t;

  localparam int DEF_DUTY_W    = 8;
  localparam int DEF_FREQ_W    = 8;
  localparam int DEF_RAMP_STEP = 4;

endpackage

// File: rtl/duty_stepper.sv
// Combinational duty step: moves current toward target by at most RAMP_STEP
// (RAMP_STEP=0 jumps straight to target). Never overshoots or wraps.
module duty_stepper #(
  parameter int DUTY_W    = 8,
  parameter int RAMP_STEP = 4
) (
  input  logic [DUTY_W-1:0] current,
  input  logic [DUTY_W-1:0] target,
  output logic [DUTY_W-1:0] next_duty,
  output logic              at_target
);

  localparam logic [DUTY_W:0] STEP_CAP = (DUTY_W+1)'(RAMP_STEP);

  logic            up;
  logic [DUTY_W:0] diff;
  logic [DUTY_W:0] step;

  always_comb begin
    up   = (target > current);
    diff = up ? ({1'b0, target} - {1'b0, current})
              : ({1'b0, current} - {1'b0, target});
    // A step never exceeds the remaining distance, so the result saturates at target.
    step = ((RAMP_STEP == 0) || (diff <= STEP_CAP)) ? diff : STEP_CAP;
    next_duty = up ? (current + step[DUTY_W-1:0]) : (current - step[DUTY_W-1:0]);
    at_target = (current == target);
  end

endmodule

// File: rtl/pwm_cfg_scheduler.sv
// Applies duty/divider/enable requests to the PWM only at period boundaries,
// ramping duty in bounded steps and ramping down to zero before disabling.
module pwm_cfg_scheduler
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W    = DEF_DUTY_W,
  parameter int FREQ_W    = DEF_FREQ_W,
  parameter int RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] duty_req,
  input  logic [FREQ_W-1:0] freq_req,
  input  logic              en_req,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty_o,
  output logic [FREQ_W-1:0] freq_o,
  output logic              enable_o,
  output logic              busy_o,
  output logic              commit_o
);

  sched_state_t      state_reg, state_next;
  logic [DUTY_W-1:0] duty_pend;
  logic [FREQ_W-1:0] freq_pend;
  logic              en_pend;

  logic [DUTY_W-1:0] duty_next;
  logic [FREQ_W-1:0] freq_next;
  logic              enable_next;

  logic [DUTY_W-1:0] step_duty;
  logic [DUTY_W-1:0] down_duty;
  logic              at_target;
  logic              at_zero;
  logic              reached;

  duty_stepper #(.DUTY_W(DUTY_W), .RAMP_STEP(RAMP_STEP)) u_step_target (
    .current   (duty_o),
    .target    (duty_pend),
    .next_duty (step_duty),
    .at_target (at_target)
  );

  duty_stepper #(.DUTY_W(DUTY_W), .RAMP_STEP(RAMP_STEP)) u_step_zero (
    .current   (duty_o),
    .target    ('0),
    .next_duty (down_duty),
    .at_target (at_zero)
  );

  assign reached = (step_duty == duty_pend);

  always_comb begin
    state_next  = state_reg;
    duty_next   = duty_o;
    freq_next   = freq_o;
    enable_next = enable_o;
    unique case (state_reg)
      IDLE: begin
        freq_next = freq_pend;
        if (en_pend) begin
          enable_next = 1'b1;
          state_next  = (duty_pend != '0) ? RAMP : RUN;
        end
      end
      RUN, RAMP: begin
        if (period_end) begin
          freq_next = freq_pend;
          if (!en_pend) begin
            duty_next  = down_duty;
            state_next = STOP;
          end else if (!at_target || state_reg == RAMP) begin
            duty_next  = step_duty;
            state_next = reached ? RUN : RAMP;
          end
        end
      end
      STOP: begin
        // The divider is frozen while winding down; re-enable resumes normal tracking.
        if (period_end) begin
          if (en_pend) begin
            freq_next  = freq_pend;
            duty_next  = step_duty;
            state_next = reached ? RUN : RAMP;
          end else if (at_zero) begin
            enable_next = 1'b0;
            state_next  = IDLE;
          end else begin
            duty_next = down_duty;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      duty_pend <= '0;
      freq_pend <= '0;
      en_pend   <= 1'b0;
      duty_o    <= '0;
      freq_o    <= '0;
      enable_o  <= 1'b0;
      busy_o    <= 1'b0;
      commit_o  <= 1'b0;
    end else begin
      state_reg <= state_next;
      duty_pend <= duty_req;
      freq_pend <= freq_req;
      en_pend   <= en_req;
      duty_o    <= duty_next;
      freq_o    <= freq_next;
      enable_o  <= enable_next;
      busy_o    <= (state_next == RAMP) || (state_next == STOP);
      commit_o  <= (duty_next != duty_o) || (freq_next != freq_o) || (enable_next != enable_o);
    end
  end

endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// Directed plus randomized bench for pwm_cfg_scheduler, checked every cycle
// against a behavioural model of the scheduling rules.
module tb_pwm_cfg_scheduler;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] duty_req;
  logic [7:0] freq_req;
  logic       en_req;
  logic       period_end;
  logic [7:0] duty_o;
  logic [7:0] freq_o;
  logic       enable_o;
  logic       busy_o;
  logic       commit_o;

  int n_vec  = 0;
  int n_fail = 0;

  // model: applied outputs plus a "winding down" flag
  int m_duty, m_freq, p_duty, p_freq;
  bit m_en, m_stop, m_busy, m_commit, p_en;

  always #5 clk = ~clk;

  pwm_cfg_scheduler #(.DUTY_W(8), .FREQ_W(8), .RAMP_STEP(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .duty_req   (duty_req),
    .freq_req   (freq_req),
    .en_req     (en_req),
    .period_end (period_end),
    .duty_o     (duty_o),
    .freq_o     (freq_o),
    .enable_o   (enable_o),
    .busy_o     (busy_o),
    .commit_o   (commit_o)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int toward(input int cur, input int tgt);
    int d, s;
    d = (cur > tgt) ? cur - tgt : tgt - cur;
    s = (S == 0 || d <= S) ? d : S;
    return (cur < tgt) ? cur + s : cur - s;
  endfunction

  task automatic model_edge();
    int od, of;
    bit oe;
    od = m_duty; of = m_freq; oe = m_en;
    if (rst) begin
      m_duty = 0; m_freq = 0; m_en = 0; m_stop = 0; m_busy = 0; m_commit = 0;
      p_duty = 0; p_freq = 0; p_en = 0;
      return;
    end
    if (!m_en) begin
      m_freq = p_freq;
      if (p_en) begin
        m_en = 1;
        m_busy = (p_duty != 0);
      end
    end else if (period_end) begin
      if (!p_en) begin
        if (m_stop && m_duty == 0) begin
          m_en = 0; m_stop = 0; m_busy = 0;
        end else begin
          if (!m_stop) m_freq = p_freq;
          m_duty = toward(m_duty, 0);
          m_stop = 1; m_busy = 1;
        end
      end else begin
        m_freq = p_freq;
        m_duty = toward(m_duty, p_duty);
        m_stop = 0;
        m_busy = (m_duty != p_duty);
      end
    end
    m_commit = (od != m_duty) || (of != m_freq) || (oe != m_en);
    p_duty = duty_req; p_freq = freq_req; p_en = en_req;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("duty_o", int'(duty_o), m_duty);
    chk("freq_o", int'(freq_o), m_freq);
    chk("enable_o", int'(enable_o), int'(m_en));
    chk("busy_o", int'(busy_o), int'(m_busy));
    chk("commit_o", int'(commit_o), int'(m_commit));
  endtask

  task automatic pulse();
    period_end = 1'b1;
    cycle();
    period_end = 1'b0;
    cycle();
  endtask

  // Pulse period_end until duty settles at want (bounded).
  task automatic settle(input string tag, input int want);
    for (int k = 0; k < 100 && !(int'(duty_o) == want && !busy_o); k++) pulse();
    chk(tag, int'(duty_o), want);
  endtask

  initial begin
    rst = 1'b1; duty_req = 8'd0; freq_req = 8'd0; en_req = 1'b0; period_end = 1'b0;
    m_duty = 0; m_freq = 0; m_en = 0; m_stop = 0; m_busy = 0; m_commit = 0;
    p_duty = 0; p_freq = 0; p_en = 0;

    // reset while inputs wiggle
    for (int i = 0; i < 2; i++) begin
      duty_req = 8'($urandom); freq_req = 8'($urandom); en_req = 1'b1; period_end = 1'b1;
      cycle();
    end
    chk("rst_duty", int'(duty_o), 0);
    chk("rst_en", int'(enable_o), 0);
    chk("rst_commit", int'(commit_o), 0);
    rst = 1'b0; period_end = 1'b0; en_req = 1'b0; duty_req = 8'd0; freq_req = 8'd0;
    cycle();

    // enable with duty 128, freq 10
    duty_req = 8'd128; freq_req = 8'd10; en_req = 1'b1;
    cycle(); cycle();
    chk("en_enable", int'(enable_o), 1);
    chk("en_freq", int'(freq_o), 10);
    chk("en_duty", int'(duty_o), 0);
    for (int i = 1; i <= 32; i++) begin
      period_end = 1'b1;
      cycle();
      chk("ramp_up", int'(duty_o), 4 * i);
      period_end = 1'b0;
      cycle();
    end
    chk("ramp_done_busy", int'(busy_o), 0);

    // non-multiple target from duty 0
    duty_req = 8'd0;
    settle("to_zero", 0);
    duty_req = 8'd10;
    cycle(); cycle();
    pulse(); chk("nm_4", int'(duty_o), 4);
    pulse(); chk("nm_8", int'(duty_o), 8);
    pulse(); chk("nm_10", int'(duty_o), 10);
    chk("nm_busy", int'(busy_o), 0);
    duty_req = 8'd3;
    cycle();
    pulse(); chk("nm_6", int'(duty_o), 6);
    pulse(); chk("nm_3", int'(duty_o), 3);

    // mid-period change at 128
    duty_req = 8'd128;
    settle("to_128", 128);
    duty_req = 8'd100; freq_req = 8'd20;
    repeat (5) cycle();
    chk("mid_hold_freq", int'(freq_o), 10);
    pulse();
    chk("mid_freq", int'(freq_o), 20);
    chk("mid_duty", int'(duty_o), 124);

    // disable from duty 8
    duty_req = 8'd8;
    settle("to_8", 8);
    en_req = 1'b0;
    cycle();
    pulse(); chk("dis_4", int'(duty_o), 4);
    pulse(); chk("dis_0", int'(duty_o), 0);
    chk("dis_still_en", int'(enable_o), 1);
    pulse(); chk("dis_off", int'(enable_o), 0);
    repeat (3) pulse();

    // reset mid-ramp at duty 60, coincident with period_end
    duty_req = 8'd200; en_req = 1'b1;
    cycle(); cycle();
    for (int k = 0; k < 40 && int'(duty_o) != 60; k++) pulse();
    chk("pre_rst_duty", int'(duty_o), 60);
    rst = 1'b1; period_end = 1'b1;
    cycle();
    rst = 1'b0; period_end = 1'b0;
    chk("mr_duty", int'(duty_o), 0);
    chk("mr_en", int'(enable_o), 0);
    chk("mr_busy", int'(busy_o), 0);

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) duty_req = 8'($urandom);
      if ($urandom_range(0, 59) == 0) freq_req = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      if ($urandom_range(0, 149) == 0) en_req = ~en_req;
      period_end = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 999) == 0);
      cycle();
    end
    rst = 1'b0; period_end = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
